if_id_queue: RTL

- Sits between the instruction fetcher and the decoder.
- Owns the architectural fetch PC and sequences the fetcher's request/done/ack handshake.
- Buffers fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects from execute: flushes buffered entries and discards any in-flight fetch.

---
 rtl/if_id_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: owns the fetch PC, sequences the fetcher request/done/ack
// handshake and queues fetched instructions for decode. `IF_ID_PERF_EN adds perf counters.
module if_id_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_enable,
    output logic [63:0] pc_current,
    output logic [63:0] target_address,
    output logic        select_target,
    output logic        if_id_pipeline_valid,
    input  logic        fetcher_done,
    input  logic [63:0] instruction_out,
    input  logic [63:0] address_out,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
`ifdef IF_ID_PERF_EN
    output logic [63:0] perf_fetches,
    output logic [31:0] perf_discards,
    output logic [63:0] perf_full_stalls,
`endif
    output logic [1:0]  dbg_state
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ACK} state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, discard;
    logic          unused_ok;

    // Address echo and upper data half are informational only.
    assign unused_ok = ^{address_out, instruction_out[63:32]};

    // Decode handshake: the head transfers on a cycle where id_valid && id_ready; a
    // redirect in the same cycle voids the transfer because the whole FIFO is flushed.
    assign pop = id_valid && id_ready && !redirect_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        push         = 1'b0;
        discard      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect_valid && count_q < DEPTH_C) begin
                    state_d      = FETCH;
                    fetch_addr_d = pc_q;
                end
            end
            FETCH: begin
                if (fetcher_done) begin
                    state_d = ACK;
                    if (redirect_valid) begin
                        discard = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_q + 64'd4;
                    end
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fetcher_done) begin
                    state_d = ACK;
                    discard = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (!redirect_valid && (count_q - CW'(pop)) < DEPTH_C) begin
                    state_d      = FETCH;
                    fetch_addr_d = pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            count_q      <= count_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= instruction_out[31:0];
                pc_mem_q[wr_ptr_q]    <= pc_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end
        end
    end

    // A fetch only starts with a free slot, so a push can never meet a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && count_q == DEPTH_C));
        end
    end

    assign fetch_enable         = (state_q != IDLE);
    assign if_id_pipeline_valid = (state_q == ACK);
    assign pc_current           = fetch_addr_q;
    assign target_address       = fetch_addr_q;
    assign select_target        = 1'b0;
    assign id_valid             = (count_q != '0);
    assign id_instr             = instr_mem_q[rd_ptr_q];
    assign id_pc                = pc_mem_q[rd_ptr_q];
    assign dbg_state            = state_q;

`ifdef IF_ID_PERF_EN
    logic [63:0] perf_fetches_q, perf_full_stalls_q;
    logic [31:0] perf_discards_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetches_q     <= '0;
            perf_discards_q    <= '0;
            perf_full_stalls_q <= '0;
        end else begin
            if (push && perf_fetches_q != '1) begin
                perf_fetches_q <= perf_fetches_q + 64'd1;
            end
            if (discard && perf_discards_q != '1) begin
                perf_discards_q <= perf_discards_q + 32'd1;
            end
            if (state_q == IDLE && count_q == DEPTH_C && perf_full_stalls_q != '1) begin
                perf_full_stalls_q <= perf_full_stalls_q + 64'd1;
            end
        end
    end

    assign perf_fetches     = perf_fetches_q;
    assign perf_discards    = perf_discards_q;
    assign perf_full_stalls = perf_full_stalls_q;
`endif
endmodule
